cnn_train_sequencer: RTL and testbench

- Parametrised training/evaluation controller for the CNN datapath (conv, maxpool, flatten, fcl, softmax).
- Sequences weight-init steps, per-image fetch handshake, settle delay, softmax start/done handshake, argmax scoring and accuracy counting.
- Supports multi-epoch runs and mini-batch gradient accumulation with a per-batch weight commit.
- Replaces the single-image, batch-size-1, free-running control previously embedded in the top level.

---
 rtl/cnn_pkg.sv | 38 +++
 rtl/cnn_train_sequencer_argmax_unit.sv | 26 ++
 rtl/cnn_train_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_cnn_train_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN training controller and its helpers.
package cnn_pkg;

    // Default score word format of the fcl outputs (signed fixed point).
    localparam int WIDTH             = 32;
    localparam int FIXED_POINT_INDEX = 16;

    // Default datapath sizes, used for the convenience count typedefs below.
    localparam int DEFAULT_NUM_CLASSES = 10;
    localparam int DEFAULT_NUM_IMAGES  = 10000;
    localparam int DEFAULT_NUM_EPOCHS  = 1;
    localparam int DEFAULT_INIT_STEPS  = 1701;

    // Width of a counter/index able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Count-width typedefs for the default-sized network.
    typedef logic [$clog2(DEFAULT_NUM_IMAGES)-1:0]   img_idx_t;
    typedef logic [$clog2(DEFAULT_NUM_IMAGES+1)-1:0] img_count_t;
    typedef logic [$clog2(DEFAULT_INIT_STEPS)-1:0]   init_addr_t;
    typedef logic [$clog2(DEFAULT_NUM_EPOCHS+1)-1:0] epoch_count_t;
    typedef logic [$clog2(DEFAULT_NUM_CLASSES)-1:0]  class_idx_t;

    // Sequencer states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_FETCH     = 3'd2,
        S_SETTLE    = 3'd3,
        S_FORWARD   = 3'd4,
        S_SCORE     = 3'd5,
        S_EPOCH_END = 3'd6,
        S_DONE      = 3'd7
    } seq_state_t;

endpackage

// File: rtl/cnn_train_sequencer_argmax_unit.sv
// Combinational argmax over signed class scores; ties resolve to the lowest index.
module argmax_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH       = 32
) (
    input  logic [NUM_CLASSES-1:0][WIDTH-1:0]        scores,
    output logic [cnn_pkg::cnt_w(NUM_CLASSES)-1:0]   max_idx
);

    localparam int PW = cnn_pkg::cnt_w(NUM_CLASSES);

    logic signed [WIDTH-1:0] best_val;

    // Linear scan; a strictly-greater compare keeps the earliest of equal maxima.
    always_comb begin
        best_val = $signed(scores[0]);
        max_idx  = '0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if ($signed(scores[i]) > best_val) begin
                best_val = $signed(scores[i]);
                max_idx  = PW'(i);
            end
        end
    end

endmodule

// File: rtl/cnn_train_sequencer.sv
// Training/evaluation sequencer: weight init sweep, per-image fetch, forward pass
// handshake, argmax scoring, accuracy counting and mini-batch weight commits.
module cnn_train_sequencer #(
    parameter int WIDTH         = 32,
    parameter int NUM_CLASSES   = 10,
    parameter int NUM_IMAGES    = 10000,
    parameter int NUM_EPOCHS    = 1,
    parameter int BATCH_SIZE    = 1,
    parameter int INIT_STEPS    = 1701,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       train,
    output logic                                       img_req,
    input  logic                                       img_ready,
    output logic [cnn_pkg::cnt_w(NUM_IMAGES)-1:0]      img_index,
    output logic                                       init_en,
    output logic [cnn_pkg::cnt_w(INIT_STEPS)-1:0]      init_addr,
    output logic                                       fwd_start,
    input  logic                                       fwd_done,
    input  logic [NUM_CLASSES-1:0][WIDTH-1:0]          scores,
    input  logic [NUM_CLASSES-1:0]                     labels,
    output logic                                       grad_accum_en,
    output logic                                       weight_commit,
    output logic [cnn_pkg::cnt_w(NUM_IMAGES+1)-1:0]    correct_count,
    output logic [cnn_pkg::cnt_w(NUM_IMAGES+1)-1:0]    last_epoch_correct,
    output logic [cnn_pkg::cnt_w(NUM_EPOCHS+1)-1:0]    epoch,
    output logic                                       busy,
    output logic                                       done
);

    import cnn_pkg::*;

    localparam int IW = cnt_w(NUM_IMAGES);
    localparam int AW = cnt_w(INIT_STEPS);
    localparam int CW = cnt_w(NUM_IMAGES + 1);
    localparam int EW = cnt_w(NUM_EPOCHS + 1);
    localparam int BW = cnt_w(BATCH_SIZE);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam int PW = cnt_w(NUM_CLASSES);

    localparam logic [IW-1:0] IMG_LAST    = IW'(NUM_IMAGES - 1);
    localparam logic [AW-1:0] INIT_LAST   = AW'(INIT_STEPS - 1);
    localparam logic [EW-1:0] EPOCH_LAST  = EW'(NUM_EPOCHS - 1);
    localparam logic [BW-1:0] BATCH_LAST  = BW'(BATCH_SIZE - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [BW-1:0]   batch_cnt;
    logic            mode_r;
    logic            fwd_armed;
    logic [PW-1:0]   pred_idx;
    logic            is_correct;
    logic            last_img;
    logic            batch_full;

    argmax_unit #(
        .NUM_CLASSES (NUM_CLASSES),
        .WIDTH       (WIDTH)
    ) u_argmax (
        .scores  (scores),
        .max_idx (pred_idx)
    );

    assign is_correct = labels[pred_idx];
    assign last_img   = (img_index == IMG_LAST);
    assign batch_full = (batch_cnt == BATCH_LAST);

    // State register; an asserted reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all per-state control outputs and pulses.
    always_comb begin
        state_nxt     = state;
        init_en       = 1'b0;
        img_req       = 1'b0;
        fwd_start     = 1'b0;
        grad_accum_en = 1'b0;
        weight_commit = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                init_en = 1'b1;
                if (init_addr == INIT_LAST) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                img_req = 1'b1;
                if (img_ready) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_FORWARD;
                end
            end
            S_FORWARD: begin
                fwd_start = fwd_armed;
                if (!fwd_armed && fwd_done) begin
                    state_nxt = S_SCORE;
                end
            end
            S_SCORE: begin
                if (mode_r) begin
                    grad_accum_en = 1'b1;
                    weight_commit = batch_full || last_img;
                end else begin
                    // An eval image may still close out a batch left pending by earlier train images.
                    weight_commit = last_img && (batch_cnt != '0);
                end
                state_nxt = last_img ? S_EPOCH_END : S_FETCH;
            end
            S_EPOCH_END: begin
                state_nxt = (epoch == EPOCH_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, latched mode and accuracy bookkeeping, advanced by the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_index          <= '0;
            init_addr          <= '0;
            settle_cnt         <= '0;
            batch_cnt          <= '0;
            mode_r             <= 1'b0;
            fwd_armed          <= 1'b0;
            correct_count      <= '0;
            last_epoch_correct <= '0;
            epoch              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_index     <= '0;
                        init_addr     <= '0;
                        settle_cnt    <= '0;
                        batch_cnt     <= '0;
                        mode_r        <= 1'b0;
                        fwd_armed     <= 1'b0;
                        correct_count <= '0;
                        epoch         <= '0;
                    end
                end
                S_INIT: begin
                    if (init_addr != INIT_LAST) begin
                        init_addr <= init_addr + AW'(1);
                    end
                end
                S_FETCH: begin
                    settle_cnt <= '0;
                    if (img_ready) begin
                        mode_r <= train;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        fwd_armed <= 1'b1;
                    end
                end
                S_FORWARD: begin
                    fwd_armed <= 1'b0;
                end
                S_SCORE: begin
                    if (is_correct) begin
                        correct_count <= correct_count + CW'(1);
                    end
                    if (weight_commit) begin
                        batch_cnt <= '0;
                    end else if (mode_r) begin
                        batch_cnt <= batch_cnt + BW'(1);
                    end
                    if (!last_img) begin
                        img_index <= img_index + IW'(1);
                    end
                end
                S_EPOCH_END: begin
                    last_epoch_correct <= correct_count;
                    correct_count      <= '0;
                    img_index          <= '0;
                    epoch              <= epoch + EW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Self-checking bench for cnn_train_sequencer using a small two-epoch configuration.
module tb_cnn_train_sequencer;

    localparam int NC = 4;
    localparam int W  = 16;

    typedef struct packed {
        bit ok;
        bit acc;
        bit com;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              train;
    logic              img_req;
    logic              img_ready;
    logic [1:0]        img_index;
    logic              init_en;
    logic [2:0]        init_addr;
    logic              fwd_start;
    logic              fwd_done;
    logic [NC-1:0][W-1:0] scores;
    logic [NC-1:0]     labels;
    logic              grad_accum_en;
    logic              weight_commit;
    logic [2:0]        correct_count;
    logic [2:0]        last_epoch_correct;
    logic [1:0]        epoch;
    logic              busy;
    logic              done;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   model_img;
    int   model_cc;
    int   model_epoch;
    int   model_last;

    cnn_train_sequencer #(
        .WIDTH         (W),
        .NUM_CLASSES   (NC),
        .NUM_IMAGES    (4),
        .NUM_EPOCHS    (2),
        .BATCH_SIZE    (3),
        .INIT_STEPS    (5),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .train              (train),
        .img_req            (img_req),
        .img_ready          (img_ready),
        .img_index          (img_index),
        .init_en            (init_en),
        .init_addr          (init_addr),
        .fwd_start          (fwd_start),
        .fwd_done           (fwd_done),
        .scores             (scores),
        .labels             (labels),
        .grad_accum_en      (grad_accum_en),
        .weight_commit      (weight_commit),
        .correct_count      (correct_count),
        .last_epoch_correct (last_epoch_correct),
        .epoch              (epoch),
        .busy               (busy),
        .done               (done)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait was somehow bypassed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [NC-1:0][W-1:0] mk(input int a, input int b, input int c, input int d);
        logic [NC-1:0][W-1:0] r;
        r[0] = W'(a);
        r[1] = W'(b);
        r[2] = W'(c);
        r[3] = W'(d);
        return r;
    endfunction

    task automatic test_reset();
        reset     = 1'b0;
        start     = 1'b0;
        train     = 1'b0;
        img_ready = 1'b0;
        fwd_done  = 1'b0;
        scores    = '0;
        labels    = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, init_en, img_req, fwd_start, grad_accum_en, weight_commit} !== 7'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {busy, done, init_en, img_req, fwd_start, grad_accum_en, weight_commit});
        end
        n_vec++;
        if ({img_index, init_addr, correct_count, last_epoch_correct, epoch} !== 13'b0) begin
            n_err++;
            $display("[TB] FAIL reset_counts: got %b expected 0",
                     {img_index, init_addr, correct_count, last_epoch_correct, epoch});
        end
        reset = 1'b1;
    endtask

    task automatic test_init();
        int cnt;
        int cyc;
        cnt         = 0;
        cyc         = 0;
        model_img   = 0;
        model_cc    = 0;
        model_epoch = 0;
        start       = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (init_en === 1'b1) begin
                n_vec++;
                if (init_addr !== 3'(cnt)) begin
                    n_err++;
                    $display("[TB] FAIL init_addr: got %0d expected %0d", init_addr, cnt);
                end
                cnt++;
            end
            if (img_req === 1'b1) break;
        end
        n_vec++;
        if (cnt != 5 || img_req !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL init_cycles: got %0d expected 5 (img_req=%b)", cnt, img_req);
        end
    endtask

    task automatic wait_fwd_start(output bit seen);
        int cyc;
        cyc  = 0;
        seen = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (fwd_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("[TB] FAIL fwd_start_timeout: got no pulse expected one within 20 cycles");
        end
    endtask

    task automatic drive_image(input bit tr, input logic [NC-1:0][W-1:0] sc, input logic [NC-1:0] lab,
                               input int stall, output bit ok);
        int cyc;
        cyc = 0;
        while (img_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (img_req !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL img_req_timeout: got %b expected 1", img_req);
            ok = 0;
            return;
        end
        n_vec++;
        if (img_index !== 2'(model_img)) begin
            n_err++;
            $display("[TB] FAIL img_index: got %0d expected %0d", img_index, model_img);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_vec++;
            if (img_req !== 1'b1 || fwd_start !== 1'b0 || img_index !== 2'(model_img)) begin
                n_err++;
                $display("[TB] FAIL fetch_stall: got req=%b fwd=%b idx=%0d expected req=1 fwd=0 idx=%0d",
                         img_req, fwd_start, img_index, model_img);
            end
        end
        train     = tr;
        scores    = sc;
        labels    = lab;
        img_ready = 1'b1;
        @(negedge clk);
        img_ready = 1'b0;
        train     = ~tr;
        ok        = 1;
    endtask

    task automatic do_image(input bit tr, input logic [NC-1:0][W-1:0] sc, input logic [NC-1:0] lab,
                            input bit exp_ok, input bit exp_acc, input bit exp_com,
                            input int stall, input bit early_done);
        exp_t e;
        bit   ok;
        bit   seen;
        drive_image(tr, sc, lab, stall, ok);
        if (!ok) return;
        sb.push_back('{ok: exp_ok, acc: exp_acc, com: exp_com});
        wait_fwd_start(seen);
        if (!seen) return;
        fwd_done = early_done;
        @(negedge clk);
        n_vec++;
        if (fwd_start !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL fwd_start_width: got %b expected 0 on second cycle", fwd_start);
        end
        if (early_done) begin
            fwd_done = 1'b0;
            repeat (2) begin
                @(negedge clk);
                n_vec++;
                if (img_req !== 1'b0 || grad_accum_en !== 1'b0 || correct_count !== 3'(model_cc)
                    || epoch !== 2'(model_epoch)) begin
                    n_err++;
                    $display("[TB] FAIL early_done_ignored: got req=%b acc=%b cc=%0d ep=%0d expected 0 0 %0d %0d",
                             img_req, grad_accum_en, correct_count, epoch, model_cc, model_epoch);
                end
            end
        end
        fwd_done = 1'b1;
        @(negedge clk);
        fwd_done = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (grad_accum_en !== e.acc || weight_commit !== e.com) begin
            n_err++;
            $display("[TB] FAIL score_pulses img%0d: got acc=%b com=%b expected acc=%b com=%b",
                     model_img, grad_accum_en, weight_commit, e.acc, e.com);
        end
        if (e.ok) model_cc++;
        @(negedge clk);
        n_vec++;
        if (correct_count !== 3'(model_cc) || grad_accum_en !== 1'b0 || weight_commit !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL correct_count img%0d: got %0d (acc=%b com=%b) expected %0d (0 0)",
                     model_img, correct_count, grad_accum_en, weight_commit, model_cc);
        end
        if (model_img == 3) begin
            @(negedge clk);
            model_epoch++;
            model_last = model_cc;
            model_cc   = 0;
            model_img  = 0;
            n_vec++;
            if (last_epoch_correct !== 3'(model_last) || epoch !== 2'(model_epoch)
                || correct_count !== 3'd0 || img_index !== 2'd0) begin
                n_err++;
                $display("[TB] FAIL epoch_end: got last=%0d ep=%0d cc=%0d idx=%0d expected %0d %0d 0 0",
                         last_epoch_correct, epoch, correct_count, img_index, model_last, model_epoch);
            end
        end else begin
            model_img++;
        end
    endtask

    task automatic test_train_epoch();
        do_image(1'b1, mk(9, 1, 2, 3),  4'b0001, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        do_image(1'b1, mk(1, 9, 2, 3),  4'b0010, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        do_image(1'b1, mk(1, 2, 9, 3),  4'b0100, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        do_image(1'b1, mk(1, 2, 3, 9),  4'b1000, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_eval_epoch();
        do_image(1'b0, mk(5, 9, 9, -3),   4'b0010, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_image(1'b0, mk(5, 9, 9, -3),   4'b0100, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_image(1'b0, mk(-8, -2, -5, -9), 4'b0010, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_image(1'b0, mk(1, 2, 3, 4),    4'b1000, 1'b1, 1'b0, 1'b0, 10, 1'b1);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || epoch !== 2'd2 || last_epoch_correct !== 3'd3) begin
            n_err++;
            $display("[TB] FAIL run_done: got done=%b busy=%b ep=%0d last=%0d expected 1 0 2 3",
                     done, busy, epoch, last_epoch_correct);
        end
    endtask

    task automatic test_back_to_idle();
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || epoch !== 2'd2 || last_epoch_correct !== 3'd3) begin
            n_err++;
            $display("[TB] FAIL idle_retain: got done=%b busy=%b ep=%0d last=%0d expected 0 0 2 3",
                     done, busy, epoch, last_epoch_correct);
        end
    endtask

    task automatic test_reset_mid_forward();
        bit ok;
        bit seen;
        test_init();
        drive_image(1'b1, mk(1, 9, 2, 3), 4'b0010, 0, ok);
        if (!ok) return;
        wait_fwd_start(seen);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, fwd_start, img_req, init_en, grad_accum_en, weight_commit} !== 7'b0
            || last_epoch_correct !== 3'd0 || epoch !== 2'd0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_forward: got ctrl=%b last=%0d ep=%0d expected 0000000 0 0",
                     {busy, done, fwd_start, img_req, init_en, grad_accum_en, weight_commit},
                     last_epoch_correct, epoch);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || init_en !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_idle_hold: got busy=%b init_en=%b expected 0 0", busy, init_en);
        end
        test_init();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_last = 0;
        test_reset();
        test_init();
        test_train_epoch();
        test_eval_epoch();
        test_back_to_idle();
        test_reset_mid_forward();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
